msg_sequencer: RTL and testbench
================================

Name: msg_sequencer

Overview:
- Parametrised message sequencer. On a send trigger, or on a periodic auto trigger, it streams one stored message, character by character, from a synchronous character ROM into a serial transmitter.
- The message is selected by the switch inputs. Its base address and length come from an external descriptor table.
- Replaces the fixed-delay start pulse with a ready/start handshake to the transmitter.
- Sits between the board inputs (already debounced), char_rom, and the UART transmitter.

Parameters:
- SEL_W, 4, width of the message select input
- ADDR_W, 6, character ROM address width
- LEN_W, 6, message length width (maximum message length 2^LEN_W-1)
- DATA_W, 8, character width
- CHAR_DIV, 78105, sysclk cycles between character slots (minimum 2)
- AUTO_DIV, 33554432, sysclk cycles between auto triggers (minimum 2)

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  SEL_W  message select (switches)
- btn_send  in  1  send request, one-cycle pulse (debounced)
- btn_auto  in  1  toggles auto mode, one-cycle pulse (debounced)
- abort  in  1  stop the current message after the character in flight
- desc_sel  out  SEL_W  select value driven to the descriptor table
- desc_base  in  ADDR_W  base address of the selected message (combinational from table)
- desc_len  in  LEN_W  length of the selected message (combinational from table)
- rom_addr  out  ADDR_W  character ROM address
- rom_data  in  DATA_W  ROM data, valid 1 cycle after rom_addr
- tx_ready  in  1  transmitter idle/ready
- tx_start  out  1  one-cycle start strobe to the transmitter
- tx_data  out  DATA_W  character, held stable from tx_start until the next tx_start
- busy  out  1  a message is in progress
- auto_on  out  1  auto mode active
- done  out  1  one-cycle pulse when a message completes or is aborted

Behaviour:
- Reset (asynchronous, rst_n=0) clears every output and all state:
  - tx_start=0, tx_data=0, rom_addr=0, desc_sel=0, busy=0, auto_on=0, done=0
  - FSM=IDLE; both dividers cleared; pending flag cleared.
- desc_sel follows sel combinationally while the FSM is in IDLE. It is frozen (registered) once a message starts.
- Trigger definition: trigger = btn_send | (auto_tick & auto_on).
  - auto_tick is a one-cycle pulse every AUTO_DIV cycles from a free-running divider.
  - btn_auto toggles auto_on on each pulse.
- Trigger while busy sets a one-deep pending flag. Further triggers while the flag is set are dropped.
- FSM states: IDLE, LOAD, FETCH, WAIT_RDY, SEND, GAP.
  - IDLE: on trigger or pending, go to LOAD and clear pending.
  - LOAD: latch base=desc_base, len=desc_len, idx=0; freeze desc_sel. If len==0, pulse done and return to IDLE. Otherwise go to FETCH.
  - FETCH: rom_addr = base+idx, modulo 2^ADDR_W (wraps; no saturation). Go to WAIT_RDY after 1 cycle, which covers the ROM latency.
  - WAIT_RDY: capture rom_data into tx_data once. Stay until tx_ready=1, then go to SEND.
  - SEND: tx_start=1 for exactly one cycle; idx increments. Go to GAP.
  - GAP: wait for char_tick, a pulse every CHAR_DIV cycles from a free-running divider. On tick: if idx==len or abort was seen, pulse done and go to IDLE; otherwise go to FETCH.
- abort is latched whenever busy. It takes effect only at GAP; a character already in WAIT_RDY is still sent. abort in IDLE has no effect.
- busy=1 in every state except IDLE.
- Character rate is bounded both by char_tick and by tx_ready.
- Simultaneous events:
  - done and trigger in the same cycle: the trigger is recorded as pending and the next message starts 1 cycle after IDLE is entered.
  - btn_send and auto_tick together count as one trigger.

Decomposition:
- Package msg_seq_pkg holds:
  - FSM state encoding constants
  - default CHAR_DIV and AUTO_DIV values
  - a simulation-friendly AUTO_DIV value (e.g. 2^19)
- Sub-module tick_div: free-running counter with parameter DIV, outputs a one-cycle pulse, uses asynchronous active-low reset. Instantiated twice (char_tick, auto_tick).
- The descriptor table and char_rom stay external.

Test Plan:
- Reset mid-message: assert rst_n=0 in SEND -> tx_start=0, busy=0, auto_on=0 immediately; no further tx_start after release.
- Basic message: sel=1, desc_base=0, desc_len=13, tx_ready=1, CHAR_DIV=4 -> 13 tx_start pulses 4 cycles apart, rom_addr 0..12, tx_data equals the ROM contents, done pulses once, busy falls.
- Backpressure and wrap: desc_base=62, desc_len=4, tx_ready held low 10 cycles per character -> rom_addr 62,63,0,1; each tx_start occurs only while tx_ready=1; tx_data stable between strobes.
- Zero length and sel change: desc_len=0 -> done 2 cycles after btn_send, no tx_start. Changing sel mid-message leaves desc_sel and rom_addr sequence unchanged.
- Pending and auto: btn_send twice during a message -> exactly one extra message follows; a third pulse is dropped. btn_auto with AUTO_DIV=200 -> the message repeats every auto_tick; a second btn_auto stops repeats.
- Abort: abort at the 3rd character of 13 -> exactly 3 tx_start pulses, then done and busy=0.

Source files
------------

// File: rtl/msg_seq_pkg.sv
// Shared types and constants for the message sequencer and its tick dividers.
package msg_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_SEND     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // Board-rate defaults: CHAR_DIV gives roughly one character slot per UART frame
  // at the board clock, AUTO_DIV gives an auto repeat a few times per second.
  localparam int unsigned DEFAULT_CHAR_DIV = 78105;
  localparam int unsigned DEFAULT_AUTO_DIV = 33554432;

  // Shorter auto period so auto repeats are reachable in simulation.
  localparam int unsigned SIM_AUTO_DIV = 524288;

  // Counter width needed to count 0..div-1 (never less than one bit).
  function automatic int unsigned divWidth(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/msg_sequencer_tick_div.sv
// Free-running divider producing a one-cycle pulse every DIV clock cycles.
module tick_div
  import msg_seq_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CNT_W = divWidth(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;

  // Count 0..DIV-1 and wrap; the pulse marks the last count of each period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/msg_sequencer.sv
// Streams one stored message from the character ROM into the UART transmitter,
// started by a button press or a periodic auto trigger, with ready/start handshake.
module msg_sequencer
  import msg_seq_pkg::*;
#(
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHAR_DIV = DEFAULT_CHAR_DIV,
  parameter int unsigned AUTO_DIV = DEFAULT_AUTO_DIV
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic              btn_send,
  input  logic              btn_auto,
  input  logic              abort,
  output logic [SEL_W-1:0]  desc_sel,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [LEN_W-1:0]  desc_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              auto_on,
  output logic              done
);

  state_t            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_char;
  logic              r_captured;
  logic              r_pending;
  logic              r_abort;
  logic              r_auto_on;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_done;

  logic              w_char_tick;
  logic              w_auto_tick;
  logic              w_trigger;
  logic              w_busy;
  logic              w_abort_seen;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_char;

  tick_div #(.DIV(CHAR_DIV)) u_char_div (
    .i_clk   (sysclk),
    .i_rst_n (rst_n),
    .o_tick  (w_char_tick)
  );

  tick_div #(.DIV(AUTO_DIV)) u_auto_div (
    .i_clk   (sysclk),
    .i_rst_n (rst_n),
    .o_tick  (w_auto_tick)
  );

  // A button press and an auto tick in the same cycle merge into one trigger.
  assign w_trigger    = btn_send | (w_auto_tick & r_auto_on);
  assign w_busy       = (r_state != ST_IDLE);
  // An abort arriving in the very cycle the gap ends still stops the message.
  assign w_abort_seen = r_abort | abort;
  // Address arithmetic wraps around the ROM instead of saturating.
  assign w_next_addr  = r_base + ADDR_W'(r_idx);
  // The first WAIT_RDY cycle sees the ROM word directly; later cycles use the held copy.
  assign w_char       = r_captured ? r_char : rom_data;

  // The table sees the live switches only while idle so a message cannot change mid-stream.
  assign desc_sel = (r_state == ST_IDLE) ? sel : r_sel;
  assign rom_addr = r_rom_addr;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = w_busy;
  assign auto_on  = r_auto_on;
  assign done     = r_done;

  // Each auto button pulse flips auto mode.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_on <= 1'b0;
    end else if (btn_auto) begin
      r_auto_on <= ~r_auto_on;
    end
  end

  // Message FSM with registered strobes, pending-trigger and abort bookkeeping.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_char     <= '0;
      r_captured <= 1'b0;
      r_pending  <= 1'b0;
      r_abort    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_rom_addr <= '0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;

      if (w_busy && w_trigger) begin
        r_pending <= 1'b1;
      end
      if (w_busy && abort) begin
        r_abort <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_sel   <= sel;
          r_abort <= 1'b0;
          if (w_trigger || r_pending) begin
            r_pending <= 1'b0;
            r_state   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_base     <= desc_base;
          r_len      <= desc_len;
          r_idx      <= '0;
          r_rom_addr <= desc_base;
          if (desc_len == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          r_captured <= 1'b0;
          r_state    <= ST_WAIT_RDY;
        end

        ST_WAIT_RDY: begin
          if (!r_captured) begin
            r_char     <= rom_data;
            r_captured <= 1'b1;
          end
          if (tx_ready) begin
            r_tx_data  <= w_char;
            r_tx_start <= 1'b1;
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          r_idx   <= r_idx + LEN_W'(1);
          r_state <= ST_GAP;
        end

        ST_GAP: begin
          if (w_char_tick) begin
            if ((r_idx == r_len) || w_abort_seen) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_rom_addr <= w_next_addr;
              r_state    <= ST_FETCH;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// Scoreboard bench for msg_sequencer with a model ROM, descriptor table and transmitter.
module tb_msg_sequencer;

  localparam int CHAR_DIV = 4;
  localparam int AUTO_DIV = 200;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } expChar_t;

  logic       sysclk;
  logic       rst_n;
  logic [3:0] sel;
  logic       btn_send;
  logic       btn_auto;
  logic       abort;
  logic [3:0] desc_sel;
  logic [5:0] desc_base;
  logic [5:0] desc_len;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       auto_on;
  logic       done;

  int numChecks = 0;
  int numFails  = 0;
  int cycleCount = 0;
  bit bpMode = 0;
  bit exactGap = 0;

  logic [7:0] romMem [64];
  expChar_t   charQ[$];
  int         doneQ[$];

  msg_sequencer #(
    .SEL_W(4), .ADDR_W(6), .LEN_W(6), .DATA_W(8),
    .CHAR_DIV(CHAR_DIV), .AUTO_DIV(AUTO_DIV)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .sel(sel), .btn_send(btn_send),
    .btn_auto(btn_auto), .abort(abort), .desc_sel(desc_sel),
    .desc_base(desc_base), .desc_len(desc_len), .rom_addr(rom_addr),
    .rom_data(rom_data), .tx_ready(tx_ready), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .auto_on(auto_on), .done(done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cycleCount <= cycleCount + 1;

  // Synchronous character ROM: data follows the address by one clock.
  initial begin
    for (int i = 0; i < 64; i++) romMem[i] = 8'(i * 7 + 48);
  end
  always @(posedge sysclk) rom_data <= romMem[rom_addr];

  // Descriptor table: sel 1 = 13 chars at 0, sel 2 = 4 chars at 62 (wraps), sel 3 = empty, sel 4 = 3 chars at 20.
  function automatic logic [5:0] tabBase(input logic [3:0] s);
    case (s)
      4'd1:    return 6'd0;
      4'd2:    return 6'd62;
      4'd4:    return 6'd20;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] tabLen(input logic [3:0] s);
    case (s)
      4'd1:    return 6'd13;
      4'd2:    return 6'd4;
      4'd4:    return 6'd3;
      default: return 6'd0;
    endcase
  endfunction

  always_comb begin
    desc_base = tabBase(desc_sel);
    desc_len  = tabLen(desc_sel);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic failBound(input string name);
    numChecks++;
    numFails++;
    $display("[TB] FAIL %s: actual=timeout required=event within bound", name);
  endtask

  // Transmitter model: goes busy for 10 cycles after each start when backpressure is on.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge sysclk);
      if (bpMode && tx_start) begin
        #1 tx_ready = 1'b0;
        repeat (10) @(negedge sysclk);
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes a character or signals done.
  initial begin
    expChar_t e;
    logic [7:0] lastTxData;
    int charCount;
    int lastStart;
    lastTxData = '0;
    charCount  = 0;
    lastStart  = 0;
    forever begin
      @(negedge sysclk);
      if (!rst_n) begin
        lastTxData = tx_data;
        charCount  = 0;
      end else begin
        if (tx_start) begin
          checkOutput("tx_ready at tx_start", 32'(tx_ready), 32'd1);
          if (charQ.size() == 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL unexpected tx_start: actual addr=%0d required=no strobe", rom_addr);
          end else begin
            e = charQ.pop_front();
            checkOutput("rom_addr", 32'(rom_addr), 32'(e.addr));
            checkOutput("tx_data", 32'(tx_data), 32'(e.data));
          end
          if (charCount >= 1) begin
            numChecks++;
            if (cycleCount - lastStart < CHAR_DIV) begin
              numFails++;
              $display("[TB] FAIL char spacing: actual=%0d required>=%0d", cycleCount - lastStart, CHAR_DIV);
            end
          end
          if (exactGap && charCount >= 2)
            checkOutput("steady char spacing", 32'(cycleCount - lastStart), 32'(CHAR_DIV));
          lastStart = cycleCount;
          charCount++;
        end else begin
          checkOutput("tx_data stable", 32'(tx_data), 32'(lastTxData));
        end
        lastTxData = tx_data;
        if (done) begin
          checkOutput("busy at done", 32'(busy), 32'd0);
          if (doneQ.size() == 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL unexpected done: actual=1 required=0");
          end else begin
            checkOutput("chars per message", 32'(charCount), 32'(doneQ.pop_front()));
          end
          charCount = 0;
        end
      end
    end
  end

  task automatic pushMessage(input logic [3:0] s, input int n);
    expChar_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = tabBase(s) + 6'(i);
      e.data = romMem[e.addr];
      charQ.push_back(e);
    end
    doneQ.push_back(n);
  endtask

  task automatic applyStimulus(input logic [3:0] s, input int nExpected, input bit doPush);
    sel = s;
    @(negedge sysclk);
    btn_send = 1'b1;
    if (doPush) pushMessage(s, nExpected);
    @(negedge sysclk);
    btn_send = 1'b0;
  endtask

  task automatic pulseAuto();
    @(negedge sysclk);
    btn_auto = 1'b1;
    @(negedge sysclk);
    btn_auto = 1'b0;
  endtask

  task automatic pulseAbort();
    @(negedge sysclk);
    abort = 1'b1;
    @(negedge sysclk);
    abort = 1'b0;
  endtask

  task automatic waitStart(input int maxCycles, output bit found);
    found = 1'b0;
    for (int n = 0; n < maxCycles; n++) begin
      @(negedge sysclk);
      if (tx_start) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n;
    n = 0;
    while ((charQ.size() != 0 || doneQ.size() != 0 || busy) && n < maxCycles) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput(name, 32'(charQ.size() + doneQ.size()), 32'd0);
    repeat (2) @(negedge sysclk);
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    sel      = 4'd0;
    btn_send = 1'b0;
    btn_auto = 1'b0;
    abort    = 1'b0;
    repeat (3) @(negedge sysclk);

    checkOutput("reset tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset desc_sel", 32'(desc_sel), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset auto_on", 32'(auto_on), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // Reset in the middle of a message.
    sel = 4'd1;
    pulseAuto();
    checkOutput("auto_on after toggle", 32'(auto_on), 32'd1);
    applyStimulus(4'd1, 13, 1'b1);
    waitStart(50, found);
    if (!found) failBound("first tx_start before reset");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset tx_start", 32'(tx_start), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset auto_on", 32'(auto_on), 32'd0);
    charQ.delete();
    doneQ.delete();
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (60) @(negedge sysclk);
    checkOutput("idle after reset release", 32'(busy), 32'd0);

    // Basic 13-character message; sel changes mid-message.
    exactGap = 1'b1;
    applyStimulus(4'd1, 13, 1'b1);
    repeat (20) @(negedge sysclk);
    sel = 4'd2;
    #1;
    checkOutput("desc_sel frozen", 32'(desc_sel), 32'd1);
    waitDrain("basic message drained", 200);
    exactGap = 1'b0;
    checkOutput("desc_sel follows sel when idle", 32'(desc_sel), 32'd2);

    // Backpressure with address wrap 62,63,0,1.
    bpMode = 1'b1;
    applyStimulus(4'd2, 4, 1'b1);
    waitDrain("backpressure message drained", 300);
    bpMode = 1'b0;
    repeat (12) @(negedge sysclk);

    // Zero-length message: done two cycles after the press, no characters.
    applyStimulus(4'd3, 0, 1'b1);
    checkOutput("zero-length done early", 32'(done), 32'd0);
    @(negedge sysclk);
    checkOutput("zero-length done", 32'(done), 32'd1);
    waitDrain("zero-length drained", 20);

    // Two extra presses during a message: one pending, one dropped.
    applyStimulus(4'd4, 3, 1'b1);
    repeat (3) @(negedge sysclk);
    applyStimulus(4'd4, 3, 1'b1);
    repeat (3) @(negedge sysclk);
    applyStimulus(4'd4, 0, 1'b0);
    checkOutput("busy during third press", 32'(busy), 32'd1);
    waitDrain("pending messages drained", 300);

    // Auto mode for exactly 600 cycles: three auto ticks, three messages.
    sel = 4'd4;
    pulseAuto();
    checkOutput("auto_on enabled", 32'(auto_on), 32'd1);
    pushMessage(4'd4, 3);
    pushMessage(4'd4, 3);
    pushMessage(4'd4, 3);
    repeat (598) @(negedge sysclk);
    pulseAuto();
    checkOutput("auto_on disabled", 32'(auto_on), 32'd0);
    waitDrain("auto messages drained", 300);
    repeat (500) @(negedge sysclk);
    checkOutput("no repeat after auto off", 32'(busy), 32'd0);

    // Abort while idle is ignored; abort at the third character stops after it.
    pulseAbort();
    applyStimulus(4'd4, 3, 1'b1);
    waitDrain("message after idle abort", 100);
    applyStimulus(4'd1, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      waitStart(50, found);
      if (!found) failBound("tx_start before abort");
    end
    abort = 1'b1;
    @(negedge sysclk);
    abort = 1'b0;
    waitDrain("aborted message drained", 100);
    checkOutput("busy after abort", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  // Safety net in case any wait above misbehaves.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
